dmem_arbiter: RTL and testbench

Shares the single data memory between the pipeline's execute-stage load/store port and an external requester (debug/loader port).
The CPU has priority. The external port uses a req/ack handshake and is served in CPU-idle cycles.
A starvation counter forces a one-cycle pipeline stall so that an external access always completes within a bounded time.
The block sits between the execute-stage dmem outputs and the dmem macro, which has separate read and write ports and a synchronous read with 1-cycle latency.

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle: CPU execute-stage port, external req/ack port and the
// dmem macro port. The arbiter takes the slave view; its environment takes the master view.
interface dmem_arbiter_if #(
    parameter int unsigned DMEM_ADDR_WIDTH = 12,
    parameter int unsigned DMEM_WORD_WIDTH = 16
);
    // CPU execute-stage port
    logic                       in_cpu_rd_en;
    logic [DMEM_ADDR_WIDTH-1:0] in_cpu_rd_addr;
    logic                       in_cpu_wr_en;
    logic [DMEM_ADDR_WIDTH-1:0] in_cpu_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] in_cpu_wr_word;
    logic [DMEM_WORD_WIDTH-1:0] out_cpu_rd_word;
    logic                       out_cpu_stall;

    // External requester port
    logic                       in_ext_req;
    logic                       in_ext_we;
    logic [DMEM_ADDR_WIDTH-1:0] in_ext_addr;
    logic [DMEM_WORD_WIDTH-1:0] in_ext_wr_word;
    logic                       out_ext_ack;
    logic [DMEM_WORD_WIDTH-1:0] out_ext_rd_word;

    // dmem macro port
    logic                       out_dmem_rd_en;
    logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr;
    logic                       out_dmem_wr_en;
    logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr;
    logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word;
    logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word;

    modport slave (
        input  in_cpu_rd_en, in_cpu_rd_addr, in_cpu_wr_en, in_cpu_wr_addr, in_cpu_wr_word,
        output out_cpu_rd_word, out_cpu_stall,
        input  in_ext_req, in_ext_we, in_ext_addr, in_ext_wr_word,
        output out_ext_ack, out_ext_rd_word,
        output out_dmem_rd_en, out_dmem_rd_addr, out_dmem_wr_en, out_dmem_wr_addr,
        output out_dmem_wr_word,
        input  in_dmem_rd_word
    );

    modport master (
        output in_cpu_rd_en, in_cpu_rd_addr, in_cpu_wr_en, in_cpu_wr_addr, in_cpu_wr_word,
        input  out_cpu_rd_word, out_cpu_stall,
        output in_ext_req, in_ext_we, in_ext_addr, in_ext_wr_word,
        input  out_ext_ack, out_ext_rd_word,
        input  out_dmem_rd_en, out_dmem_rd_addr, out_dmem_wr_en, out_dmem_wr_addr,
        input  out_dmem_wr_word,
        output in_dmem_rd_word
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter. The CPU owns the dmem by default; an external requester is slotted
// into CPU-idle cycles, and after STARVE_LIMIT busy cycles the pipeline is stalled for one
// cycle so the external access is guaranteed to issue.
module dmem_arbiter #(
    parameter int unsigned DMEM_ADDR_WIDTH  = 12,
    parameter int unsigned DMEM_WORD_WIDTH  = 16,
    parameter int unsigned STARVE_LIMIT     = 4,
    parameter int unsigned STARVE_CNT_WIDTH = 3
) (
    input logic              clock,
    input logic              reset,
    dmem_arbiter_if.slave    bus
);

    localparam logic [STARVE_CNT_WIDTH-1:0] StarveMax = STARVE_CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StWait, StResp, StAck} state_e;

    state_e                      state_q;
    logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q;
    logic                        ext_ack_q;
    logic [DMEM_WORD_WIDTH-1:0]  ext_rd_word_q;
    logic                        ext_rd_q;      // transaction in flight is a read

    logic cpu_busy;
    logic starved;
    logic ext_issue;
    logic force_issue;

    // Arbitration decision for the current cycle
    always_comb begin
        cpu_busy    = bus.in_cpu_rd_en | bus.in_cpu_wr_en;
        starved     = (starve_cnt_q == StarveMax);
        ext_issue   = bus.in_ext_req &&
                      (((state_q == StIdle) && !cpu_busy) ||
                       ((state_q == StWait) && (!cpu_busy || starved)));
        force_issue = bus.in_ext_req && (state_q == StWait) && cpu_busy && starved;
    end

    // dmem port routing; everything forced to zero while reset is held
    always_comb begin
        bus.out_dmem_rd_en   = 1'b0;
        bus.out_dmem_rd_addr = '0;
        bus.out_dmem_wr_en   = 1'b0;
        bus.out_dmem_wr_addr = '0;
        bus.out_dmem_wr_word = '0;
        bus.out_cpu_stall    = 1'b0;
        if (reset) begin
            bus.out_cpu_stall = force_issue;
            if (ext_issue) begin
                if (bus.in_ext_we) begin
                    bus.out_dmem_wr_en   = 1'b1;
                    bus.out_dmem_wr_addr = bus.in_ext_addr;
                    bus.out_dmem_wr_word = bus.in_ext_wr_word;
                end else begin
                    bus.out_dmem_rd_en   = 1'b1;
                    bus.out_dmem_rd_addr = bus.in_ext_addr;
                end
            end else begin
                bus.out_dmem_rd_en = bus.in_cpu_rd_en;
                bus.out_dmem_wr_en = bus.in_cpu_wr_en;
                if (bus.in_cpu_rd_en) begin
                    bus.out_dmem_rd_addr = bus.in_cpu_rd_addr;
                end
                if (bus.in_cpu_wr_en) begin
                    bus.out_dmem_wr_addr = bus.in_cpu_wr_addr;
                    bus.out_dmem_wr_word = bus.in_cpu_wr_word;
                end
            end
        end
    end

    // External transaction FSM with starvation counter and registered ack/read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            starve_cnt_q  <= '0;
            ext_ack_q     <= 1'b0;
            ext_rd_word_q <= '0;
            ext_rd_q      <= 1'b0;
        end else begin
            ext_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_ext_req) begin
                        if (!cpu_busy) begin
                            state_q  <= StResp;
                            ext_rd_q <= !bus.in_ext_we;
                        end else begin
                            state_q      <= StWait;
                            starve_cnt_q <= STARVE_CNT_WIDTH'(1);
                        end
                    end
                end
                StWait: begin
                    if (!bus.in_ext_req) begin
                        // Request withdrawn early: abandon and rearm
                        state_q      <= StIdle;
                        starve_cnt_q <= '0;
                    end else if (ext_issue) begin
                        state_q      <= StResp;
                        starve_cnt_q <= '0;
                        ext_rd_q     <= !bus.in_ext_we;
                    end else begin
                        starve_cnt_q <= starve_cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (ext_rd_q) begin
                        ext_rd_word_q <= bus.in_dmem_rd_word;
                    end
                    ext_ack_q <= 1'b1;
                    state_q   <= StAck;
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_ext_ack     = ext_ack_q;
    assign bus.out_ext_rd_word = ext_rd_word_q;
    assign bus.out_cpu_rd_word = bus.in_dmem_rd_word;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency dmem model.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_dmem_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned WW = 16;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fails;

    dmem_arbiter_if #(.DMEM_ADDR_WIDTH(AW), .DMEM_WORD_WIDTH(WW)) bus ();

    dmem_arbiter #(
        .DMEM_ADDR_WIDTH (AW),
        .DMEM_WORD_WIDTH (WW),
        .STARVE_LIMIT    (4),
        .STARVE_CNT_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // dmem macro model: synchronous read, separate write port
    logic [WW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.out_dmem_wr_en) mem[bus.out_dmem_wr_addr] <= bus.out_dmem_wr_word;
        if (bus.out_dmem_rd_en) bus.in_dmem_rd_word <= mem[bus.out_dmem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic rd, input logic [AW-1:0] ra, input logic wr,
                       input logic [AW-1:0] wa, input logic [WW-1:0] ww);
        bus.in_cpu_rd_en   = rd;
        bus.in_cpu_rd_addr = ra;
        bus.in_cpu_wr_en   = wr;
        bus.in_cpu_wr_addr = wa;
        bus.in_cpu_wr_word = ww;
    endtask

    task automatic ext(input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [WW-1:0] w);
        bus.in_ext_req     = req;
        bus.in_ext_we      = we;
        bus.in_ext_addr    = a;
        bus.in_ext_wr_word = w;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        bus.in_dmem_rd_word = '0;
        reset = 1'b0;
        cpu(1'b1, 12'h010, 1'b0, 12'h000, 16'h0000);
        ext(1'b0, 1'b0, 12'h000, 16'h0000);

        // Reset held: outputs zero despite CPU read
        @(negedge clock); #1;
        chk("rst_rd_en", 32'(bus.out_dmem_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h0);
        chk("rst_stall", 32'(bus.out_cpu_stall), 32'd0);
        chk("rst_ack", 32'(bus.out_ext_ack), 32'd0);
        chk("rst_rd_word", 32'(bus.out_ext_rd_word), 32'h0);

        // 1. CPU only
        @(negedge clock); reset = 1'b1; cpu(1'b1, 12'h010, 1'b0, 12'h000, 16'h0000); #1;
        chk("t1_rd_en", 32'(bus.out_dmem_rd_en), 32'd1);
        chk("t1_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h010);
        chk("t1_wr_en", 32'(bus.out_dmem_wr_en), 32'd0);
        chk("t1_wr_addr0", 32'(bus.out_dmem_wr_addr), 32'h0);
        @(negedge clock); cpu(1'b0, 12'h010, 1'b1, 12'h020, 16'hBEEF); #1;
        chk("t1_wr_en2", 32'(bus.out_dmem_wr_en), 32'd1);
        chk("t1_wr_addr", 32'(bus.out_dmem_wr_addr), 32'h020);
        chk("t1_wr_word", 32'(bus.out_dmem_wr_word), 32'hBEEF);
        chk("t1_rd_en2", 32'(bus.out_dmem_rd_en), 32'd0);
        chk("t1_rd_addr2", 32'(bus.out_dmem_rd_addr), 32'h0);
        chk("t1_stall", 32'(bus.out_cpu_stall), 32'd0);
        chk("t1_ack", 32'(bus.out_ext_ack), 32'd0);

        // 2. Ext write then ext read, CPU idle
        @(negedge clock); cpu(1'b0, 12'h0, 1'b0, 12'h0, 16'h0);
        ext(1'b1, 1'b1, 12'h0AB, 16'h1234); #1;
        chk("t2w_c0_wr_en", 32'(bus.out_dmem_wr_en), 32'd1);
        chk("t2w_c0_wr_addr", 32'(bus.out_dmem_wr_addr), 32'h0AB);
        chk("t2w_c0_wr_word", 32'(bus.out_dmem_wr_word), 32'h1234);
        chk("t2w_c0_rd_en", 32'(bus.out_dmem_rd_en), 32'd0);
        chk("t2w_c0_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t2w_c1_ack", 32'(bus.out_ext_ack), 32'd0);
        chk("t2w_c1_wr_en", 32'(bus.out_dmem_wr_en), 32'd0);
        @(negedge clock); #1;
        chk("t2w_c2_ack", 32'(bus.out_ext_ack), 32'd1);
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        @(negedge clock); ext(1'b1, 1'b0, 12'h0AB, 16'h0); #1;
        chk("t2r_c0_ack", 32'(bus.out_ext_ack), 32'd0);
        chk("t2r_c0_rd_en", 32'(bus.out_dmem_rd_en), 32'd1);
        chk("t2r_c0_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h0AB);
        @(negedge clock); #1;
        chk("t2r_c1_cpu_word", 32'(bus.out_cpu_rd_word), 32'h1234);
        chk("t2r_c1_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t2r_c2_ack", 32'(bus.out_ext_ack), 32'd1);
        chk("t2r_c2_rd_word", 32'(bus.out_ext_rd_word), 32'h1234);
        ext(1'b0, 1'b0, 12'h0, 16'h0);

        // 3. CPU busy cycles 0-1, idle cycle 2; ext read of 0x020
        @(negedge clock); cpu(1'b1, 12'h100, 1'b0, 12'h0, 16'h0);
        ext(1'b1, 1'b0, 12'h020, 16'h0); #1;
        chk("t3_c0_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h100);
        chk("t3_c0_stall", 32'(bus.out_cpu_stall), 32'd0);
        @(negedge clock); #1;
        chk("t3_c1_stall", 32'(bus.out_cpu_stall), 32'd0);
        chk("t3_c1_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h100);
        @(negedge clock); cpu(1'b0, 12'h0, 1'b0, 12'h0, 16'h0); #1;
        chk("t3_c2_rd_en", 32'(bus.out_dmem_rd_en), 32'd1);
        chk("t3_c2_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h020);
        chk("t3_c2_stall", 32'(bus.out_cpu_stall), 32'd0);
        @(negedge clock); #1;
        chk("t3_c3_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t3_c4_ack", 32'(bus.out_ext_ack), 32'd1);
        chk("t3_c4_rd_word", 32'(bus.out_ext_rd_word), 32'hBEEF);
        ext(1'b0, 1'b0, 12'h0, 16'h0);

        // 4. CPU busy continuously: forced stall in cycle 4, ack in cycle 6
        for (int c = 0; c <= 6; c++) begin
            @(negedge clock);
            if (c == 0) begin
                cpu(1'b1, 12'h300, 1'b1, 12'h301, 16'h7777);
                ext(1'b1, 1'b1, 12'h055, 16'hA5A5);
            end
            #1;
            chk($sformatf("t4_c%0d_stall", c), 32'(bus.out_cpu_stall), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t4_c%0d_ack", c), 32'(bus.out_ext_ack), (c == 6) ? 32'd1 : 32'd0);
            if (c == 4) begin
                chk("t4_c4_wr_addr", 32'(bus.out_dmem_wr_addr), 32'h055);
                chk("t4_c4_wr_word", 32'(bus.out_dmem_wr_word), 32'hA5A5);
                chk("t4_c4_rd_en", 32'(bus.out_dmem_rd_en), 32'd0);
                chk("t4_c4_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h0);
            end else begin
                chk($sformatf("t4_c%0d_wr_addr", c), 32'(bus.out_dmem_wr_addr), 32'h301);
                chk($sformatf("t4_c%0d_rd_addr", c), 32'(bus.out_dmem_rd_addr), 32'h300);
            end
        end
        chk("t4_rd_word_kept", 32'(bus.out_ext_rd_word), 32'hBEEF);
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        cpu(1'b0, 12'h0, 1'b0, 12'h0, 16'h0);

        // 5. Reset during RESP aborts; pending request re-arbitrated
        @(negedge clock); ext(1'b1, 1'b0, 12'h0AB, 16'h0); #1;
        chk("t5_c0_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h0AB);
        @(negedge clock); cpu(1'b1, 12'h010, 1'b0, 12'h0, 16'h0); #1;
        chk("t5_resp_cpu_addr", 32'(bus.out_dmem_rd_addr), 32'h010);
        reset = 1'b0; #1;
        chk("t5_rst_rd_en", 32'(bus.out_dmem_rd_en), 32'd0);
        chk("t5_rst_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h0);
        chk("t5_rst_rd_word", 32'(bus.out_ext_rd_word), 32'h0);
        chk("t5_rst_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); cpu(1'b0, 12'h0, 1'b0, 12'h0, 16'h0); #1;
        chk("t5_rst_ack2", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); reset = 1'b1; #1;
        chk("t5_rel_rd_en", 32'(bus.out_dmem_rd_en), 32'd1);
        chk("t5_rel_rd_addr", 32'(bus.out_dmem_rd_addr), 32'h0AB);
        chk("t5_rel_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t5_resp_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t5_ack", 32'(bus.out_ext_ack), 32'd1);
        chk("t5_rd_word", 32'(bus.out_ext_rd_word), 32'h1234);
        chk("t5_ack_rd_en", 32'(bus.out_dmem_rd_en), 32'd0);

        // 6. Request still high after ack: back-to-back transaction, acks 3 cycles apart
        @(negedge clock); #1;
        chk("t6_reissue_rd_en", 32'(bus.out_dmem_rd_en), 32'd1);
        chk("t6_reissue_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t6_resp_ack", 32'(bus.out_ext_ack), 32'd0);
        @(negedge clock); #1;
        chk("t6_ack", 32'(bus.out_ext_ack), 32'd1);
        chk("t6_rd_word", 32'(bus.out_ext_rd_word), 32'h1234);
        ext(1'b0, 1'b0, 12'h0, 16'h0);
        @(negedge clock); #1;
        chk("t6_idle_ack", 32'(bus.out_ext_ack), 32'd0);
        chk("t6_idle_rd_en", 32'(bus.out_dmem_rd_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
